// File: rtl/adjust_button_ctrl.sv
// Pushbutton conditioner for the pixel-adjust controls.
// Each KEY is synchronised, debounced and edge-detected. A small FSM then
// turns presses into single-cycle inc/dec requests, with optional
// hold-to-repeat. If both keys are held at once, output is locked out.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no key owns the output, waiting for a single clean press
// S_FIRST | press pulse issued, counting down to the first repeat
// S_REPEAT| auto-repeat running at the repeat period
// S_LOCK  | both keys seen held, silent until both are released
module adjust_button_ctrl #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit REPEAT_EN       = 1'b1,
   parameter int REPEAT_DELAY    = 12500000,
   parameter int REPEAT_PERIOD   = 2500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_up_n,
   input  logic key_dn_n,
   output logic inc,
   output logic dec,
   output logic held_up,
   output logic held_dn
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
   localparam logic [RPT_W-1:0] RPT_DLY_V = RPT_W'(REPEAT_DELAY);
   localparam logic [RPT_W-1:0] RPT_PER_V = RPT_W'(REPEAT_PERIOD);
   localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FIRST  = 2'd1,
      S_REPEAT = 2'd2,
      S_LOCK   = 2'd3
   } state_t;

   // Bit 0 is the up key and bit 1 is the down key, throughout.
   logic [1:0] key_raw;
   logic [1:0] stable;
   logic [1:0] lvl_q;
   logic [1:0] held_q;
   logic [1:0] rise;

   assign key_raw = {key_dn_n, key_up_n};

   for (genvar k = 0; k < 2; k++) begin : g_key
      // The synchroniser keeps the raw active-low value, so loading ones on
      // reset means "released".
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   synced;
      logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
      logic                   stable_q, stable_d;

      assign synced = ~sync_q[SYNC_STAGES-1];

      // Synchroniser shift chain for the raw key pin.
      always_ff @(posedge clk) begin
         if (rst) begin
            sync_q <= '1;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw[k]};
         end
      end

      // The debounce counter tracks how long the synced level has disagreed
      // with the accepted level. The accepted level flips once the counter
      // reaches the last count.
      always_comb begin
         db_cnt_d = '0;
         stable_d = stable_q;
         if (synced != stable_q) begin
            if (db_cnt_q >= DB_LAST) begin
               stable_d = synced;
            end else begin
               db_cnt_d = db_cnt_q + DB_ONE;
            end
         end
      end

      // Debounce state registers.
      always_ff @(posedge clk) begin
         if (rst) begin
            db_cnt_q <= '0;
            stable_q <= 1'b0;
         end else begin
            db_cnt_q <= db_cnt_d;
            stable_q <= stable_d;
         end
      end

      assign stable[k] = stable_q;
   end

   // lvl_q is the level the FSM decides on. held_q is that level one cycle
   // later: it is the edge-detect reference and drives held_*, so held_*
   // rises in the same cycle as the press pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         lvl_q  <= 2'b00;
         held_q <= 2'b00;
      end else begin
         lvl_q  <= stable;
         held_q <= lvl_q;
      end
   end

   assign rise = lvl_q & ~held_q;

   state_t           state_q, state_d;
   logic             act_dn_q, act_dn_d;
   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             inc_q, inc_d;
   logic             dec_q, dec_d;
   logic             act_lvl;

   assign act_lvl = act_dn_q ? lvl_q[1] : lvl_q[0];

   // Next-state and pulse decode. A both-keys condition overrides every
   // state, so a repeat can never slip out in the cycle that lockout begins.
   always_comb begin
      state_d   = state_q;
      act_dn_d  = act_dn_q;
      rpt_cnt_d = rpt_cnt_q;
      inc_d     = 1'b0;
      dec_d     = 1'b0;
      if (&lvl_q) begin
         state_d   = S_LOCK;
         rpt_cnt_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rise[0]) begin
                  inc_d     = 1'b1;
                  act_dn_d  = 1'b0;
                  rpt_cnt_d = RPT_DLY_V;
                  state_d   = S_FIRST;
               end else if (rise[1]) begin
                  dec_d     = 1'b1;
                  act_dn_d  = 1'b1;
                  rpt_cnt_d = RPT_DLY_V;
                  state_d   = S_FIRST;
               end
            end
            S_FIRST, S_REPEAT: begin
               if (!act_lvl) begin
                  state_d   = S_IDLE;
                  rpt_cnt_d = '0;
               end else if (rpt_cnt_q > RPT_ONE) begin
                  rpt_cnt_d = rpt_cnt_q - RPT_ONE;
               end else if (REPEAT_EN) begin
                  inc_d     = ~act_dn_q;
                  dec_d     = act_dn_q;
                  rpt_cnt_d = RPT_PER_V;
                  state_d   = S_REPEAT;
               end else begin
                  rpt_cnt_d = '0;
               end
            end
            S_LOCK: begin
               if (lvl_q == 2'b00) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM state, repeat timer and registered pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         act_dn_q  <= 1'b0;
         rpt_cnt_q <= '0;
         inc_q     <= 1'b0;
         dec_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         act_dn_q  <= act_dn_d;
         rpt_cnt_q <= rpt_cnt_d;
         inc_q     <= inc_d;
         dec_q     <= dec_d;
      end
   end

   assign inc     = inc_q;
   assign dec     = dec_q;
   assign held_up = held_q[0];
   assign held_dn = held_q[1];

endmodule
